// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and defaults for the matrix-multiply sequencer
package matmul_pkg;

  localparam int N_DEFAULT     = 3;
  localparam int DW_DEFAULT    = 8;
  localparam int ACC_W_DEFAULT = 18;
  localparam int IDX_W         = 2;

  localparam logic [1:0] MAT_A = 2'd0;
  localparam logic [1:0] MAT_B = 2'd1;
  localparam logic [1:0] MAT_C = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD_A,
    RD_B,
    MAC,
    WAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/matmul_sequencer_index_gen.sv
// rtl/matmul_sequencer_index_gen.sv - nested i/j/k loop counters for the product walk
module mm_index_gen
  import matmul_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc_k,
  input  logic             inc_ij,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             last_k,
  output logic             last_ij
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  assign last_k  = (k == LAST);
  assign last_ij = (i == LAST) && (j == LAST);

  // k walks the inner product; j then i advance once per finished element
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (inc_k) begin
        k <= last_k ? '0 : k + 1'b1;
      end
      if (inc_ij) begin
        if (j == LAST) begin
          j <= '0;
          i <= last_ij ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - C = A x B sequencer over a shared 1-port memory; SATURATE_EN clamps written C values
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [1:0]       matrix_select,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  input  logic [DW-1:0]    read_data,
  output logic             write_enable,
  output logic [DW-1:0]    write_data,
  output logic             mac_clr,
  output logic             mac_valid,
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  input  logic [ACC_W-1:0] mac_acc
);

  state_t           state, state_nxt;
  logic [DW-1:0]    a_reg;
  logic [DW-1:0]    c_fmt;
  logic [IDX_W-1:0] i, j, k;
  logic             last_k, last_ij;
  logic             clr_idx, inc_k, inc_ij;

  mm_index_gen #(.N(N)) u_index_gen (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr_idx),
    .inc_k   (inc_k),
    .inc_ij  (inc_ij),
    .i       (i),
    .j       (j),
    .k       (k),
    .last_k  (last_k),
    .last_ij (last_ij)
  );

`ifdef SATURATE_EN
  assign c_fmt = (|mac_acc[ACC_W-1:DW]) ? {DW{1'b1}} : mac_acc[DW-1:0];
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^mac_acc[ACC_W-1:DW];
  assign c_fmt = mac_acc[DW-1:0];
`endif

  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // hold A[i][k] while B[k][j] is being read out of the same port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
    end else if (state == RD_B) begin
      a_reg <= read_data;
    end
  end

  // next-state and Moore output decode
  always_comb begin
    state_nxt     = state;
    matrix_select = MAT_A;
    row           = '0;
    col           = '0;
    write_enable  = 1'b0;
    write_data    = '0;
    mac_clr       = 1'b0;
    mac_valid     = 1'b0;
    mac_a         = '0;
    mac_b         = '0;
    done          = 1'b0;
    clr_idx       = 1'b0;
    inc_k         = 1'b0;
    inc_ij        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLR;
      end
      CLR: begin
        mac_clr   = 1'b1;
        clr_idx   = 1'b1;
        state_nxt = RD_A;
      end
      RD_A: begin
        matrix_select = MAT_A;
        row           = i;
        col           = k;
        state_nxt     = RD_B;
      end
      RD_B: begin
        matrix_select = MAT_B;
        row           = k;
        col           = j;
        state_nxt     = MAC;
      end
      MAC: begin
        mac_valid = 1'b1;
        mac_a     = a_reg;
        mac_b     = read_data;
        inc_k     = 1'b1;
        state_nxt = last_k ? WAIT : RD_A;
      end
      WAIT: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        matrix_select = MAT_C;
        row           = i;
        col           = j;
        write_enable  = 1'b1;
        write_data    = c_fmt;
        mac_clr       = 1'b1;
        inc_ij        = 1'b1;
        state_nxt     = last_ij ? DONE : RD_A;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - scoreboard bench for matmul_sequencer
module tb_matmul_sequencer;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy, done;
  logic [1:0]       matrix_select, row, col;
  logic [DW-1:0]    read_data;
  logic             write_enable;
  logic [DW-1:0]    write_data;
  logic             mac_clr, mac_valid;
  logic [DW-1:0]    mac_a, mac_b;
  logic [ACC_W-1:0] mac_acc;

  matmul_sequencer #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .matrix_select (matrix_select),
    .row           (row),
    .col           (col),
    .read_data     (read_data),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .mac_clr       (mac_clr),
    .mac_valid     (mac_valid),
    .mac_a         (mac_a),
    .mac_b         (mac_b),
    .mac_acc       (mac_acc)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_a [N][N];
  logic [7:0] mem_b [N][N];
  logic [7:0] mem_c [N][N];
  logic [7:0] exp_c [N*N];

  // memory model: 1-cycle synchronous read, single write port
  always @(posedge clk) begin
    if (matrix_select == 2'd0)      read_data <= mem_a[row][col];
    else if (matrix_select == 2'd1) read_data <= mem_b[row][col];
    else                            read_data <= mem_c[row][col];
    if (write_enable) mem_c[row][col] <= write_data;
  end

  // external MAC model
  always @(posedge clk) begin
    if (mac_clr)        mac_acc <= '0;
    else if (mac_valid) mac_acc <= mac_acc + ACC_W'(mac_a) * ACC_W'(mac_b);
  end

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [7:0] d;
  } wr_t;

  wr_t         exp_w[$];
  logic [15:0] exp_m[$];
  int checks = 0;
  int failures = 0;
  int wcount = 0;
  int vcnt = 0;
  bit clr_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", nm);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a MAC op or a write
  always @(negedge clk) begin
    if (reset) begin
      vcnt     = 0;
      clr_seen = 0;
    end else begin
      if (mac_valid) begin
        if (exp_m.size() == 0) unexpected("mac_unexpected");
        else begin
          logic [15:0] m;
          m = exp_m.pop_front();
          chk("mac_a", mac_a, m[15:8]);
          chk("mac_b", mac_b, m[7:0]);
        end
        if (vcnt == 0) chk("clr_before_first_valid", clr_seen, 1);
        clr_seen = 0;
        vcnt++;
      end
      if (write_enable) begin
        wcount++;
        if (exp_w.size() == 0) unexpected("write_unexpected");
        else begin
          wr_t w;
          w = exp_w.pop_front();
          chk("wr_sel", matrix_select, 2);
          chk("wr_row", row, w.r);
          chk("wr_col", col, w.c);
          chk("wr_data", write_data, w.d);
        end
        chk("valids_per_element", vcnt, N);
        vcnt = 0;
      end
      if (mac_clr) clr_seen = 1;
    end
  end

  task automatic load(input int kind);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mem_c[r][c] = 8'h00;
        case (kind)
          0: begin mem_a[r][c] = (r == c) ? 8'd1 : 8'd0; mem_b[r][c] = 8'(r*N + c + 1); end
          1: begin mem_a[r][c] = 8'd2; mem_b[r][c] = 8'd3; end
          default: begin mem_a[r][c] = 8'hFF; mem_b[r][c] = 8'hFF; end
        endcase
      end
  endtask

  task automatic set_exp(input int kind);
    for (int e = 0; e < N*N; e++) begin
      case (kind)
        0: exp_c[e] = 8'(e + 1);
        1: exp_c[e] = 8'h12;
`ifdef SATURATE_EN
        default: exp_c[e] = 8'hFF;
`else
        default: exp_c[e] = 8'h03;
`endif
      endcase
    end
  endtask

  task automatic push_expected();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr_t w;
        w.r = 2'(r);
        w.c = 2'(c);
        w.d = exp_c[r*N + c];
        exp_w.push_back(w);
        for (int kk = 0; kk < N; kk++) exp_m.push_back({mem_a[r][kk], mem_b[kk][c]});
      end
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_we"}, write_enable, 0);
    chk({nm, "_mac"}, {mac_clr, mac_valid}, 0);
    chk({nm, "_addr"}, {matrix_select, row, col}, 0);
    chk({nm, "_data"}, {write_data, mac_a, mac_b}, 0);
  endtask

  task automatic run_product(input int kind, input bit pulse_busy);
    int done_cyc;
    int done_n;
    load(kind);
    set_exp(kind);
    push_expected();
    done_cyc = 0;
    done_n   = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      start = (pulse_busy && (c == 10 || c == 60)) ? 1'b1 : 1'b0;
      if (c == 1) chk("busy_after_start", busy, 1);
      if (done) begin
        done_n++;
        done_cyc = c;
      end
      if (done_cyc != 0 && c == done_cyc + 1) chk("idle_after_done", busy, 0);
      if (done_cyc != 0 && c == done_cyc + 3) break;
    end
    start = 1'b0;
    chk("done_count", done_n, 1);
    chk("done_cycle", done_cyc, 101);
    chk("writes_pending", exp_w.size(), 0);
    chk("macs_pending", exp_m.size(), 0);
  endtask

  task automatic check_mem_c(input string nm);
    for (int e = 0; e < N*N; e++) chk(nm, mem_c[e / N][e % N], exp_c[e]);
  endtask

  initial begin
    int w0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    run_product(0, 1'b0);
    check_mem_c("identity_c");

    w0 = wcount;
    run_product(1, 1'b0);
    chk("write_pulses", wcount - w0, N*N);

    run_product(2, 1'b0);

    run_product(0, 1'b1);
    run_product(0, 1'b0);
    check_mem_c("rerun_c");

    load(1);
    set_exp(1);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_idle_outputs("midrun_reset");
    exp_w.delete();
    exp_m.delete();
    w0 = wcount;
    repeat (5) begin
      @(negedge clk);
      chk("we_in_reset", write_enable, 0);
    end
    chk("writes_during_reset", wcount - w0, 0);
    reset = 1'b0;
    @(negedge clk);
    run_product(0, 1'b0);
    check_mem_c("after_reset_c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
